// File: rtl/pcie_phy_pkg.sv
// Shared definitions for the Gen3+ 128b/130b transmit path.
//   SYNC_DATA / SYNC_OS : sync header codes for data and ordered-set blocks
//   SKP_SYMBOL / SKP_END: SKP ordered-set filler and terminator symbols
//   sched_state_t       : block scheduler FSM states
package pcie_phy_pkg;

    localparam logic [1:0] SYNC_DATA  = 2'b10;
    localparam logic [1:0] SYNC_OS    = 2'b01;

    localparam logic [7:0] SKP_SYMBOL = 8'hAA;
    localparam logic [7:0] SKP_END    = 8'hE1;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_READY    = 2'd1,
        S_STREAM   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pcie_skp_timer.sv
// SKP insertion timer. Counts transferred non-SKP blocks and raises
// skp_pending once SKP_INTERVAL of them have gone out.
//   clk, reset   : clock, async active-high reset
//   count_en     : a non-SKP block transferred this cycle
//   clear        : a SKP block is being loaded (wins over count_en)
//   flush        : link disabled, restart the interval
//   skp_pending  : SKP due
module pcie_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 370
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    input  logic flush,
    output logic skp_pending
);

    localparam int unsigned CNT_W = $clog2(SKP_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL);

    logic [CNT_W-1:0] count_q, count_d;
    logic             skp_pending_q;

    // Count saturates at the interval until a SKP is loaded.
    always_comb begin
        count_d = count_q;
        if (flush || clear) begin
            count_d = '0;
        end else if (count_en && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            skp_pending_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            skp_pending_q <= (count_d == CNT_MAX);
        end
    end

    assign skp_pending = skp_pending_q;

endmodule

// File: rtl/pcie_tx_block_scheduler.sv
// Block scheduler for the 128b/130b transmit path. Picks one block per
// cycle from the link-layer data stream, the LTSSM ordered-set request or
// a timed SKP, tags it with its sync header and holds it in a valid/ready
// output register. Ordered sets are only inserted between data streams.
//   clk, reset             : clock, async active-high reset
//   link_en                : LTSSM in a transmitting state
//   data_valid/in/last     : data stream source, data_ready accepts
//   os_req/os_payload      : ordered-set request, os_ack accepts
//   skp_pending            : SKP due, upstream should close the stream
//   blk_valid/sync/payload : output block, blk_ready accepts
module pcie_tx_block_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned SKP_INTERVAL = 370
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  link_en,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_last,
    output logic                  data_ready,
    input  logic                  os_req,
    input  logic [DATA_WIDTH-1:0] os_payload,
    output logic                  os_ack,
    output logic                  skp_pending,
    output logic                  blk_valid,
    output logic [1:0]            blk_sync,
    output logic [DATA_WIDTH-1:0] blk_payload,
    input  logic                  blk_ready
);

    sched_state_t          state_q;
    logic                  blk_valid_q;
    logic [1:0]            blk_sync_q, blk_sync_d;
    logic [DATA_WIDTH-1:0] blk_payload_q, blk_payload_d;
    logic                  blk_is_skp_q;

    logic                  load_en;
    logic                  sel_skp, sel_os, sel_data, sel_idle, load;
    logic [DATA_WIDTH-1:0] skp_payload;

    assign load_en = link_en & (~blk_valid_q | blk_ready);

    always_comb begin
        skp_payload = '0;
        for (int i = 0; i < 12; i++) begin
            skp_payload[8*i +: 8] = SKP_SYMBOL;
        end
        skp_payload[8*12 +: 8] = SKP_END;
    end

    // Source select. S_DISABLED never loads; in S_STREAM the OS and SKP
    // sources are held off until the stream closes.
    always_comb begin
        sel_skp  = 1'b0;
        sel_os   = 1'b0;
        sel_data = 1'b0;
        sel_idle = 1'b0;
        if (load_en) begin
            case (state_q)
                S_READY: begin
                    if (skp_pending)     sel_skp  = 1'b1;
                    else if (os_req)     sel_os   = 1'b1;
                    else if (data_valid) sel_data = 1'b1;
                end
                S_STREAM: begin
                    if (data_valid) sel_data = 1'b1;
                    else            sel_idle = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign load       = sel_skp | sel_os | sel_data | sel_idle;
    assign data_ready = sel_data;
    assign os_ack     = sel_os;

    always_comb begin
        blk_sync_d    = (sel_data || sel_idle) ? SYNC_DATA : SYNC_OS;
        blk_payload_d = '0;
        if (sel_skp)       blk_payload_d = skp_payload;
        else if (sel_os)   blk_payload_d = os_payload;
        else if (sel_data) blk_payload_d = data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_DISABLED;
            blk_valid_q   <= 1'b0;
            blk_sync_q    <= 2'b00;
            blk_payload_q <= '0;
            blk_is_skp_q  <= 1'b0;
        end else begin
            if (!link_en) begin
                state_q <= S_DISABLED;
            end else begin
                case (state_q)
                    S_DISABLED: state_q <= S_READY;
                    S_READY:    if (sel_data && !data_last) state_q <= S_STREAM;
                    S_STREAM:   if (sel_data && data_last)  state_q <= S_READY;
                    default:    state_q <= S_DISABLED;
                endcase
            end

            // Output slice: a held block drains even with link_en low.
            if (load) begin
                blk_valid_q   <= 1'b1;
                blk_sync_q    <= blk_sync_d;
                blk_payload_q <= blk_payload_d;
                blk_is_skp_q  <= sel_skp;
            end else if (blk_ready) begin
                blk_valid_q   <= 1'b0;
            end
        end
    end

    assign blk_valid   = blk_valid_q;
    assign blk_sync    = blk_sync_q;
    assign blk_payload = blk_payload_q;

    pcie_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk         (clk),
        .reset       (reset),
        .count_en    (blk_valid_q & blk_ready & ~blk_is_skp_q),
        .clear       (sel_skp),
        .flush       (~link_en),
        .skp_pending (skp_pending)
    );

endmodule

// File: tb/tb_pcie_tx_block_scheduler.sv
module tb_pcie_tx_block_scheduler;

    localparam int DW  = 128;
    localparam int INT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          link_en;
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic          data_last;
    logic          data_ready;
    logic          os_req;
    logic [DW-1:0] os_payload;
    logic          os_ack;
    logic          skp_pending;
    logic          blk_valid;
    logic [1:0]    blk_sync;
    logic [DW-1:0] blk_payload;
    logic          blk_ready;

    pcie_tx_block_scheduler #(
        .DATA_WIDTH   (DW),
        .SKP_INTERVAL (INT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .link_en     (link_en),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .data_last   (data_last),
        .data_ready  (data_ready),
        .os_req      (os_req),
        .os_payload  (os_payload),
        .os_ack      (os_ack),
        .skp_pending (skp_pending),
        .blk_valid   (blk_valid),
        .blk_sync    (blk_sync),
        .blk_payload (blk_payload),
        .blk_ready   (blk_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: "enabled" and "inside a stream" flags, a one-entry
    // output holding slot, and an integer count of non-SKP blocks sent.
    bit          m_en, m_stream, m_valid, m_is_skp;
    logic [1:0]  m_sync;
    logic [DW-1:0] m_pay;
    int          m_cnt;

    function automatic logic [DW-1:0] skp_ref();
        logic [DW-1:0] p;
        for (int b = 0; b < 16; b++)
            p[8*b +: 8] = (b < 12) ? 8'hAA : (b == 12) ? 8'hE1 : 8'h00;
        return p;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_en = 0; m_stream = 0; m_valid = 0; m_is_skp = 0;
        m_sync = 2'b00; m_pay = '0; m_cnt = 0;
    endtask

    // bench-side source protocol state
    bit d_pend, os_done;
    int off_run;
    int rdy_pct, dv_pct, os_pct;

    task automatic do_reset_pulse();
        reset = 1'b1;
        #1;
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_skp_pending", skp_pending, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_os_ack", os_ack, 1'b0);
        check("rst_blk_payload", blk_payload, '0);
        model_reset();
        d_pend = 0; os_done = 0; os_req = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic one_cycle();
        bit pend, load_ok, xfer, ld_skp, ld_os, ld_data, ld_idle;
        // registered outputs
        check("blk_valid", blk_valid, m_valid);
        if (m_valid) begin
            check("blk_sync", blk_sync, m_sync);
            check("blk_payload", blk_payload, m_pay);
        end
        check("skp_pending", skp_pending, m_cnt == INT);

        // drive new inputs
        if (off_run > 0) begin
            link_en = 1'b0; off_run--;
        end else if ($urandom_range(99) < 2) begin
            link_en = 1'b0; off_run = $urandom_range(3);
        end else begin
            link_en = 1'b1;
        end
        blk_ready = ($urandom_range(99) < rdy_pct);
        if (os_done) begin os_req = 1'b0; os_done = 0; end
        else if (!os_req && $urandom_range(99) < os_pct) begin
            os_req = 1'b1; os_payload = rnd128();
        end
        if (!d_pend && $urandom_range(99) < dv_pct) begin
            d_pend = 1; data_in = rnd128(); data_last = ($urandom_range(3) == 0);
        end
        data_valid = d_pend;
        #1;

        // model decision for the coming edge
        pend    = (m_cnt == INT);
        load_ok = link_en && (!m_valid || blk_ready);
        xfer    = m_valid && blk_ready;
        ld_skp = 0; ld_os = 0; ld_data = 0; ld_idle = 0;
        if (link_en && m_en && load_ok) begin
            if (!m_stream) begin
                if (pend)            ld_skp  = 1;
                else if (os_req)     ld_os   = 1;
                else if (data_valid) ld_data = 1;
            end else begin
                if (data_valid) ld_data = 1;
                else            ld_idle = 1;
            end
        end
        check("data_ready", data_ready, ld_data);
        check("os_ack", os_ack, ld_os);

        // model state update
        if (!link_en) m_cnt = 0;
        else if (ld_skp) m_cnt = 0;
        else if (xfer && !m_is_skp && m_cnt < INT) m_cnt++;

        if (!link_en) begin
            m_en = 0; m_stream = 0;
        end else if (!m_en) begin
            m_en = 1;
        end else if (ld_data) begin
            m_stream = !data_last;
        end

        if (ld_skp || ld_os || ld_data || ld_idle) begin
            m_valid  = 1;
            m_is_skp = ld_skp;
            m_sync   = (ld_data || ld_idle) ? 2'b10 : 2'b01;
            m_pay    = ld_skp ? skp_ref() : ld_os ? os_payload : ld_data ? data_in : '0;
        end else if (blk_ready) begin
            m_valid = 0;
        end

        if (ld_data) d_pend = 0;
        if (ld_os)   os_done = 1;
        @(negedge clk);
    endtask

    int rdy_t[4] = '{100, 70, 30, 90};
    int dv_t[4]  = '{95, 60, 80, 20};
    int os_t[4]  = '{5, 20, 10, 30};

    initial begin
        reset = 1'b1; link_en = 1'b0; data_valid = 1'b0; data_in = '0;
        data_last = 1'b0; os_req = 1'b0; os_payload = '0; blk_ready = 1'b0;
        d_pend = 0; os_done = 0; off_run = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_blk_valid", blk_valid, 1'b0);
        check("init_blk_sync", blk_sync, 2'b00);
        check("init_skp_pending", skp_pending, 1'b0);
        check("init_data_ready", data_ready, 1'b0);
        reset = 1'b0;
        for (int ph = 0; ph < 4; ph++) begin
            rdy_pct = rdy_t[ph]; dv_pct = dv_t[ph]; os_pct = os_t[ph];
            for (int c = 0; c < 700; c++) begin
                if (c == 350) do_reset_pulse();
                one_cycle();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
